// File: rtl/bit_entry_frontend_if.sv
// Button/bit-stream bundle for bit_entry_frontend.
// The master side drives the raw buttons; the slave side (the frontend) drives the bit stream.
interface bit_entry_frontend_if;
  logic       btn0_n;
  logic       btn1_n;
  logic       sig_to_test;
  logic       ena;
  logic       err;
  logic [7:0] history;
  logic [7:0] bit_count;

  modport master (
    output btn0_n, btn1_n,
    input  sig_to_test, ena, err, history, bit_count
  );

  modport slave (
    input  btn0_n, btn1_n,
    output sig_to_test, ena, err, history, bit_count
  );
endinterface

// File: rtl/bit_entry_frontend.sv
// Two-button bit entry stage: synchronizes and debounces the "0" and "1" buttons,
// then emits one ena strobe per accepted press along with the entered bit.
// It also keeps an 8-bit history of entries and counts them.
module bit_entry_frontend #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic                  clk,
  input logic                  rst,
  bit_entry_frontend_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EMIT, WAIT_REL} state_t;

  logic [1:0] raw;
  logic [1:0] stable;
  logic [1:0] press;

  assign raw = {bus.btn1_n, bus.btn0_n};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   stable_q;
    logic                   press_q;
    logic                   s;

    assign s         = sync_q[SYNC_STAGES-1];
    assign stable[g] = stable_q;
    assign press[g]  = press_q;

    // Shift the raw active-low button through the synchronizer; reset reads as released.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
      end
    end

    // Accept a new level only after it differs from the stable level for DEBOUNCE_CYCLES
    // cycles in a row; the stable level starts as pressed so a held button cannot enter a bit.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt      <= '0;
        stable_q <= 1'b0;
        press_q  <= 1'b0;
      end else begin
        press_q <= 1'b0;
        if (s == stable_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt      <= '0;
          stable_q <= s;
          press_q  <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  state_t     state;
  logic       sig_q;
  logic       ena_q;
  logic       err_q;
  logic [7:0] history_q;
  logic [7:0] bit_count_q;

  // Entry sequencer: one press becomes one ena strobe, then wait for both buttons released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_REL;
      sig_q       <= 1'b0;
      ena_q       <= 1'b0;
      err_q       <= 1'b0;
      history_q   <= 8'h00;
      bit_count_q <= 8'h00;
    end else begin
      ena_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (press[0] && press[1]) begin
            err_q <= 1'b1;
            state <= WAIT_REL;
          end else if (press[0]) begin
            sig_q <= 1'b0;
            state <= EMIT;
          end else if (press[1]) begin
            sig_q <= 1'b1;
            state <= EMIT;
          end
        end
        EMIT: begin
          ena_q       <= 1'b1;
          history_q   <= {history_q[6:0], sig_q};
          bit_count_q <= bit_count_q + 8'd1;
          state       <= WAIT_REL;
        end
        WAIT_REL: begin
          if (&stable) begin
            state <= IDLE;
          end
        end
        default: state <= WAIT_REL;
      endcase
    end
  end

  assign bus.sig_to_test = sig_q;
  assign bus.ena         = ena_q;
  assign bus.err         = err_q;
  assign bus.history     = history_q;
  assign bus.bit_count   = bit_count_q;

endmodule

// File: tb/tb_bit_entry_frontend.sv
// Directed bench for bit_entry_frontend with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Buttons are driven on the falling edge; outputs are sampled on the falling edge
// or 1 time unit after a rising edge.
module tb_bit_entry_frontend;

  logic clk;
  logic rst;

  bit_entry_frontend_if bus ();

  bit_entry_frontend #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  int ena_count = 0;
  int err_count = 0;
  logic prev_ena = 1'b0;
  logic adjacent_seen = 1'b0;
  logic both_seen = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally strobes once per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (bus.ena) ena_count++;
    if (bus.err) err_count++;
    if (bus.ena && prev_ena) adjacent_seen = 1'b1;
    if (bus.ena && bus.err) both_seen = 1'b1;
    prev_ena = bus.ena;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One clean entry: press long enough to be accepted, then a full debounced release.
  task automatic enter_bit(input logic b);
    @(negedge clk);
    if (b) bus.btn1_n = 1'b0;
    else   bus.btn0_n = 1'b0;
    wait_cycles(12);
    bus.btn0_n = 1'b1;
    bus.btn1_n = 1'b1;
    wait_cycles(10);
  endtask

  int ena_base;
  int err_base;
  int lat;

  initial begin
    rst        = 1'b0;
    bus.btn0_n = 1'b1;
    bus.btn1_n = 1'b1;

    // Test 1: reset state and idle after reset with buttons released
    wait_cycles(3);
    check("rst_sig", 32'(bus.sig_to_test), 32'd0);
    check("rst_ena", 32'(bus.ena), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_history", 32'(bus.history), 32'h00);
    check("rst_bit_count", 32'(bus.bit_count), 32'h00);
    rst = 1'b1;
    wait_cycles(10);
    check("idle_ena_count", 32'(ena_count), 32'd0);
    check("idle_history", 32'(bus.history), 32'h00);
    check("idle_bit_count", 32'(bus.bit_count), 32'h00);

    // Test 2: clean btn1 press, ena exactly 8 rising edges after the first sampling edge
    ena_base = ena_count;
    lat = 0;
    @(negedge clk);
    bus.btn1_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.ena && lat == 0) lat = k;
    end
    wait_cycles(8);
    bus.btn1_n = 1'b1;
    wait_cycles(10);
    check("t2_latency", 32'(lat), 32'd8);
    check("t2_ena_pulses", 32'(ena_count - ena_base), 32'd1);
    check("t2_sig", 32'(bus.sig_to_test), 32'd1);
    check("t2_history", 32'(bus.history), 32'h01);
    check("t2_bit_count", 32'(bus.bit_count), 32'd1);

    // Test 3: fresh reset, then enter 0,1,0,0,1
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(10);
    ena_base = ena_count;
    enter_bit(1'b0);
    enter_bit(1'b1);
    enter_bit(1'b0);
    enter_bit(1'b0);
    enter_bit(1'b1);
    check("t3_ena_pulses", 32'(ena_count - ena_base), 32'd5);
    check("t3_history", 32'(bus.history), 32'h09);
    check("t3_bit_count", 32'(bus.bit_count), 32'd5);
    check("t3_sig", 32'(bus.sig_to_test), 32'd1);
    wait_cycles(20);
    check("t3_sig_hold", 32'(bus.sig_to_test), 32'd1);

    // Test 4: bouncing btn0 (3 low, 2 high) then steady low
    ena_base = ena_count;
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      bus.btn0_n = 1'b0;
      wait_cycles(3);
      bus.btn0_n = 1'b1;
      wait_cycles(2);
    end
    wait_cycles(4);
    check("t4_no_ena_bounce", 32'(ena_count - ena_base), 32'd0);
    bus.btn0_n = 1'b0;
    wait_cycles(15);
    bus.btn0_n = 1'b1;
    wait_cycles(12);
    check("t4_ena_pulses", 32'(ena_count - ena_base), 32'd1);
    check("t4_sig", 32'(bus.sig_to_test), 32'd0);
    check("t4_history", 32'(bus.history), 32'h12);
    check("t4_bit_count", 32'(bus.bit_count), 32'd6);

    // Test 5a: both buttons on the same cycle -> one err, no entry until both released
    ena_base = ena_count;
    err_base = err_count;
    @(negedge clk);
    bus.btn0_n = 1'b0;
    bus.btn1_n = 1'b0;
    wait_cycles(15);
    bus.btn1_n = 1'b1;
    wait_cycles(20);
    check("t5_err_pulses", 32'(err_count - err_base), 32'd1);
    check("t5_no_ena_held", 32'(ena_count - ena_base), 32'd0);
    bus.btn0_n = 1'b1;
    wait_cycles(12);
    check("t5_no_ena_release", 32'(ena_count - ena_base), 32'd0);

    // Test 5b: hold btn0, then press btn1 too -> only the btn0 entry, no err
    ena_base = ena_count;
    err_base = err_count;
    bus.btn0_n = 1'b0;
    wait_cycles(12);
    bus.btn1_n = 1'b0;
    wait_cycles(12);
    bus.btn0_n = 1'b1;
    bus.btn1_n = 1'b1;
    wait_cycles(12);
    check("t5b_ena_pulses", 32'(ena_count - ena_base), 32'd1);
    check("t5b_no_err", 32'(err_count - err_base), 32'd0);
    check("t5b_sig", 32'(bus.sig_to_test), 32'd0);
    check("t5b_history", 32'(bus.history), 32'h24);
    check("t5b_bit_count", 32'(bus.bit_count), 32'd7);

    // Test 6: btn1 held through a reset pulse produces nothing until re-pressed
    ena_base = ena_count;
    @(negedge clk);
    rst = 1'b0;
    bus.btn1_n = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(20);
    check("t6_no_ena_held", 32'(ena_count - ena_base), 32'd0);
    check("t6_bit_count_held", 32'(bus.bit_count), 32'd0);
    bus.btn1_n = 1'b1;
    wait_cycles(12);
    check("t6_no_ena_release", 32'(ena_count - ena_base), 32'd0);
    enter_bit(1'b1);
    check("t6_ena_pulses", 32'(ena_count - ena_base), 32'd1);
    check("t6_sig", 32'(bus.sig_to_test), 32'd1);
    check("t6_history", 32'(bus.history), 32'h01);
    check("t6_bit_count", 32'(bus.bit_count), 32'd1);

    // Test 6b: 255 more entries alternating 0,1,... -> 256 total, count wraps to 0
    ena_base = ena_count;
    for (int i = 0; i < 255; i++) begin
      enter_bit(i[0]);
    end
    check("wrap_ena_pulses", 32'(ena_count - ena_base), 32'd255);
    check("wrap_bit_count", 32'(bus.bit_count), 32'd0);
    check("wrap_history", 32'(bus.history), 32'hAA);
    check("wrap_sig", 32'(bus.sig_to_test), 32'd0);

    check("never_adjacent_ena", 32'(adjacent_seen), 32'd0);
    check("never_ena_with_err", 32'(both_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
